// File: rtl/pipe_ex_pkg.sv
// pipe_ex_pkg: ALU operation encodings and multiplier FSM state type
package pipe_ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_LUI = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_MUL = 4'd9
    } aluc_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/pipe_ex_mc_if.sv
// pipe_ex_mc_if: EX-stage inputs, stall handshake and EX/MEM register outputs
interface pipe_ex_mc_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            EXvalid, EXwreg, EXm2reg, EXwmem, EXshift, EXaluimm, EXflush;
    logic [3:0]      EXaluc;
    logic [REGW-1:0] EXwn;
    logic [XLEN-1:0] EXqa, EXqb, EXimmeOrSa;
    logic            EXstall;
    logic            MEMvalid, MEMwreg, MEMm2reg, MEMwmem;
    logic [REGW-1:0] MEMwn;
    logic [XLEN-1:0] MEMaluResult, MEMdi;

    modport master (
        output EXvalid, EXwreg, EXm2reg, EXwmem, EXshift, EXaluimm, EXflush,
               EXaluc, EXwn, EXqa, EXqb, EXimmeOrSa,
        input  EXstall, MEMvalid, MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMaluResult, MEMdi
    );

    modport slave (
        input  EXvalid, EXwreg, EXm2reg, EXwmem, EXshift, EXaluimm, EXflush,
               EXaluc, EXwn, EXqa, EXqb, EXimmeOrSa,
        output EXstall, MEMvalid, MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMaluResult, MEMdi
    );
endinterface

// File: rtl/pipe_ex_mul.sv
// pipe_ex_mul: iterative shift-add multiplier (low XLEN bits), used when PIPE_EX_MUL_EN is defined
module pipe_ex_mul
    import pipe_ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] qb,
    input  logic [REGW-1:0] wn,
    input  logic            wreg,
    input  logic            m2reg,
    input  logic            wmem,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] p,
    output logic [XLEN-1:0] qb_o,
    output logic [REGW-1:0] wn_o,
    output logic            wreg_o,
    output logic            m2reg_o,
    output logic            wmem_o
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    mul_state_e      state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, qb_q, qb_d;
    logic [REGW-1:0] wn_q, wn_d;
    logic [2:0]      ctl_q, ctl_d;
    logic            stall_c;

    // next state, one partial product per BUSY cycle; flush overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        qb_d    = qb_q;
        wn_d    = wn_q;
        ctl_d   = ctl_q;
        stall_c = 1'b0;
        done    = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    stall_c = 1'b1;
                    a_d     = a;
                    b_d     = b;
                    qb_d    = qb;
                    wn_d    = wn;
                    ctl_d   = {wreg, m2reg, wmem};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
                ST_BUSY: begin
                    stall_c = 1'b1;
                    acc_d   = acc_q + (b_q[cnt_q] ? a_q << cnt_q : '0);
                    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == LAST) ? ST_DONE : ST_BUSY;
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and operand registers; reset discards any multiply in progress
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            qb_q    <= '0;
            wn_q    <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            qb_q    <= qb_d;
            wn_q    <= wn_d;
            ctl_q   <= ctl_d;
        end
    end

    // stall must drop as soon as reset asserts, even while a MUL sits on the inputs
    assign stall   = stall_c & clrn;
    assign p       = acc_q;
    assign qb_o    = qb_q;
    assign wn_o    = wn_q;
    assign wreg_o  = ctl_q[2];
    assign m2reg_o = ctl_q[1];
    assign wmem_o  = ctl_q[0];
endmodule

// File: rtl/pipe_ex_mc.sv
// pipe_ex_mc: EX stage ALU plus EX/MEM register; multi-cycle MUL only when PIPE_EX_MUL_EN is defined
module pipe_ex_mc
    import pipe_ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic          clk,
    input logic          clrn,
    pipe_ex_mc_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] alua, alub, alu_res;
    logic            mul_stall, mul_done, mul_wreg, mul_m2reg, mul_wmem, load;
    logic [REGW-1:0] mul_wn;
    logic [XLEN-1:0] mul_p, mul_qb;

    logic            mem_valid_q, mem_valid_d, mem_wreg_q, mem_wreg_d;
    logic            mem_m2reg_q, mem_m2reg_d, mem_wmem_q, mem_wmem_d;
    logic [REGW-1:0] mem_wn_q, mem_wn_d;
    logic [XLEN-1:0] mem_res_q, mem_res_d, mem_di_q, mem_di_d;

    // operand select and single-cycle ALU; unknown codes yield zero
    always_comb begin
        alua    = bus.EXshift ? bus.EXimmeOrSa : bus.EXqa;
        alub    = bus.EXaluimm ? bus.EXimmeOrSa : bus.EXqb;
        alu_res = '0;
        case (bus.EXaluc)
            ALU_ADD: alu_res = alua + alub;
            ALU_SUB: alu_res = alua - alub;
            ALU_AND: alu_res = alua & alub;
            ALU_OR:  alu_res = alua | alub;
            ALU_XOR: alu_res = alua ^ alub;
            ALU_LUI: alu_res = alub << (XLEN / 2);
            ALU_SLL: alu_res = alub << alua[SHW-1:0];
            ALU_SRL: alu_res = alub >> alua[SHW-1:0];
            ALU_SRA: alu_res = $signed(alub) >>> alua[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

`ifdef PIPE_EX_MUL_EN
    pipe_ex_mul #(.XLEN(XLEN), .REGW(REGW)) u_mul (
        .clk     (clk),
        .clrn    (clrn),
        .start   (bus.EXvalid && bus.EXaluc == ALU_MUL),
        .flush   (bus.EXflush),
        .a       (alua),
        .b       (alub),
        .qb      (bus.EXqb),
        .wn      (bus.EXwn),
        .wreg    (bus.EXwreg),
        .m2reg   (bus.EXm2reg),
        .wmem    (bus.EXwmem),
        .stall   (mul_stall),
        .done    (mul_done),
        .p       (mul_p),
        .qb_o    (mul_qb),
        .wn_o    (mul_wn),
        .wreg_o  (mul_wreg),
        .m2reg_o (mul_m2reg),
        .wmem_o  (mul_wmem)
    );
`else
    assign mul_stall = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_p     = '0;
    assign mul_qb    = '0;
    assign mul_wn    = '0;
    assign mul_wreg  = 1'b0;
    assign mul_m2reg = 1'b0;
    assign mul_wmem  = 1'b0;
`endif

    // EX/MEM next contents: MUL result on DONE, ALU result on a live op, otherwise a bubble holding data
    always_comb begin
        load        = bus.EXvalid && !bus.EXflush && !mul_stall && !mul_done;
        mem_valid_d = mul_done || load;
        mem_wreg_d  = mul_done ? mul_wreg  : load && bus.EXwreg;
        mem_m2reg_d = mul_done ? mul_m2reg : load && bus.EXm2reg;
        mem_wmem_d  = mul_done ? mul_wmem  : load && bus.EXwmem;
        mem_wn_d    = mul_done ? mul_wn : (load ? bus.EXwn : mem_wn_q);
        mem_res_d   = mul_done ? mul_p  : (load ? alu_res : mem_res_q);
        mem_di_d    = mul_done ? mul_qb : (load ? bus.EXqb : mem_di_q);
    end

    // EX/MEM pipeline register, cleared asynchronously
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem_valid_q <= 1'b0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            mem_wmem_q  <= 1'b0;
            mem_wn_q    <= '0;
            mem_res_q   <= '0;
            mem_di_q    <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
            mem_wmem_q  <= mem_wmem_d;
            mem_wn_q    <= mem_wn_d;
            mem_res_q   <= mem_res_d;
            mem_di_q    <= mem_di_d;
        end
    end

    assign bus.EXstall      = mul_stall;
    assign bus.MEMvalid     = mem_valid_q;
    assign bus.MEMwreg      = mem_wreg_q;
    assign bus.MEMm2reg     = mem_m2reg_q;
    assign bus.MEMwmem      = mem_wmem_q;
    assign bus.MEMwn        = mem_wn_q;
    assign bus.MEMaluResult = mem_res_q;
    assign bus.MEMdi        = mem_di_q;
endmodule

// File: tb/tb_pipe_ex_mc.sv
// tb_pipe_ex_mc: directed and random checks of pipe_ex_mc against an arithmetic reference model
module tb_pipe_ex_mc;
    import pipe_ex_pkg::*;

    localparam int XLEN = 32;
    localparam int REGW = 5;
`ifdef PIPE_EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clrn;
    int   checks = 0;
    int   errors = 0;

    pipe_ex_mc_if #(.XLEN(XLEN), .REGW(REGW)) bus ();
    pipe_ex_mc #(.XLEN(XLEN), .REGW(REGW)) dut (.clk(clk), .clrn(clrn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference ALU: plain arithmetic on the selected operands
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = a[4:0];
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_LUI: return b * 32'd65536;
            ALU_SLL: return b << sh;
            ALU_SRL: return b >> sh;
            ALU_SRA: return b[31] ? ~((~b) >> sh) : (b >> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] qa, input logic [31:0] qb,
                         input logic [31:0] imm, input logic sh, input logic ai,
                         input logic [4:0] wn, input logic [2:0] ctl, input logic v, input logic fl);
        bus.EXaluc     = op;
        bus.EXqa       = qa;
        bus.EXqb       = qb;
        bus.EXimmeOrSa = imm;
        bus.EXshift    = sh;
        bus.EXaluimm   = ai;
        bus.EXwn       = wn;
        bus.EXwreg     = ctl[2];
        bus.EXm2reg    = ctl[1];
        bus.EXwmem     = ctl[0];
        bus.EXvalid    = v;
        bus.EXflush    = fl;
    endtask

    // one single-cycle op: no stall, then MEM holds the result or a bubble after one edge
    task automatic step_check(input string tag);
        logic [31:0] a, b, r;
        logic        live;
        a    = bus.EXshift ? bus.EXimmeOrSa : bus.EXqa;
        b    = bus.EXaluimm ? bus.EXimmeOrSa : bus.EXqb;
        r    = model(bus.EXaluc, a, b);
        live = bus.EXvalid && !bus.EXflush;
        #1;
        chk({tag, " stall"}, 64'(bus.EXstall), 64'(0));
        @(posedge clk);
        #1;
        chk({tag, " valid"}, 64'(bus.MEMvalid), 64'(live));
        chk({tag, " ctl"}, 64'({bus.MEMwreg, bus.MEMm2reg, bus.MEMwmem}),
            64'({live & bus.EXwreg, live & bus.EXm2reg, live & bus.EXwmem}));
        if (live) begin
            chk({tag, " wn"}, 64'(bus.MEMwn), 64'(bus.EXwn));
            chk({tag, " result"}, 64'(bus.MEMaluResult), 64'(r));
            chk({tag, " di"}, 64'(bus.MEMdi), 64'(bus.EXqb));
        end
    endtask

    // MUL: hold inputs until MEMvalid; count edges and stalled cycles
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          cyc, st;
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        drive(ALU_MUL, a, b, 32'd0, 1'b0, 1'b0, 5'd9, 3'b101, 1'b1, 1'b0);
        cyc = 0;
        st  = 0;
        while (cyc < 80) begin
            #1;
            if (bus.EXstall) st++;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.MEMvalid) break;
        end
        bus.EXvalid = 1'b0;
        chk({tag, " latency"}, 64'(cyc), MUL_EN ? 64'(XLEN + 2) : 64'(1));
        chk({tag, " stall cycles"}, 64'(st), MUL_EN ? 64'(XLEN + 1) : 64'(0));
        chk({tag, " result"}, 64'(bus.MEMaluResult), MUL_EN ? 64'(prod[31:0]) : 64'(0));
        chk({tag, " wn/ctl"}, 64'({bus.MEMwn, bus.MEMwreg, bus.MEMm2reg, bus.MEMwmem}), 64'({5'd9, 3'b101}));
        chk({tag, " di"}, 64'(bus.MEMdi), 64'(b));
    endtask

    initial begin
        clrn = 1'b0;
        drive(ALU_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 5'd1, 3'b111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("reset valid", 64'(bus.MEMvalid), 64'(0));
        chk("reset data", 64'({bus.MEMaluResult, bus.MEMdi}), 64'(0));
        chk("reset wn/ctl", 64'({bus.MEMwn, bus.MEMwreg, bus.MEMm2reg, bus.MEMwmem}), 64'(0));
        chk("reset stall", 64'(bus.EXstall), 64'(0));
        bus.EXvalid = 1'b0;
        #2 clrn = 1'b1;

        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 5'd3, 3'b100, 1'b1, 1'b0);
        step_check("add 5+7");
        chk("add literal", 64'(bus.MEMaluResult), 64'd12);
        drive(ALU_SRA, 32'd0, 32'h8000_0000, 32'd4, 1'b1, 1'b0, 5'd4, 3'b100, 1'b1, 1'b0);
        step_check("sra");
        chk("sra literal", 64'(bus.MEMaluResult), 64'hF800_0000);
        drive(ALU_LUI, 32'd0, 32'd0, 32'h0000_ABCD, 1'b0, 1'b1, 5'd5, 3'b100, 1'b1, 1'b0);
        step_check("lui");
        drive(ALU_SUB, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 5'd6, 3'b010, 1'b1, 1'b0);
        step_check("sub wrap");
        drive(4'd15, 32'h1234, 32'h55, 32'd0, 1'b0, 1'b0, 5'd7, 3'b111, 1'b1, 1'b0);
        step_check("undef code");
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 5'd8, 3'b111, 1'b0, 1'b0);
        step_check("invalid bubble");

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == ALU_MUL) op = ALU_ADD;
            drive(op, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom),
                  3'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
            step_check("rand");
        end

        do_mul("mul 0x10000x0x10001", 32'h0001_0000, 32'h0001_0001);
        do_mul("mul max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) do_mul("mul rand", $urandom, $urandom);

        drive(ALU_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 5'd2, 3'b100, 1'b1, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("mul busy valid", 64'(bus.MEMvalid), MUL_EN ? 64'(0) : 64'(1));
        end
        bus.EXflush = 1'b1;
        #1;
        chk("flush stall", 64'(bus.EXstall), 64'(0));
        @(posedge clk);
        #1;
        chk("flush bubble", 64'(bus.MEMvalid), 64'(0));
        drive(ALU_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 1'b0, 5'd11, 3'b100, 1'b1, 1'b0);
        step_check("add after flush");

        drive(ALU_ADD, 32'd100, 32'd1, 32'd0, 1'b0, 1'b0, 5'd7, 3'b111, 1'b1, 1'b0);
        step_check("add before reset");
        drive(ALU_MUL, 32'hFFFF, 32'hFFFF, 32'd0, 1'b0, 1'b0, 5'd9, 3'b100, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        chk("async reset data", 64'({bus.MEMaluResult, bus.MEMdi}), 64'(0));
        chk("async reset ctl", 64'({bus.MEMvalid, bus.MEMwn, bus.MEMwreg, bus.MEMm2reg, bus.MEMwmem}), 64'(0));
        chk("async reset stall", 64'(bus.EXstall), 64'(0));
        drive(ALU_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 1'b0, 5'd12, 3'b100, 1'b1, 1'b0);
        #1 clrn = 1'b1;
        step_check("xor after reset");
        do_mul("mul after reset", 32'd123, 32'd456);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ex_mc.md
PIPE_EX_MC -- requirements
Module: pipe_ex_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits (8..64, even).
REQ-002 Parameter REGW, default 5, destination register number width.
REQ-003 Port clk input 1: single clock; all state updates on rising edge.
REQ-004 Port clrn input 1: reset, asynchronous and active-low.
REQ-005 Ports EXvalid/EXwreg/EXm2reg/EXwmem/EXshift/EXaluimm input 1 each: instruction valid; decoded write-reg, mem-to-reg, write-mem, shift-source and immediate-source controls.
REQ-006 Port EXaluc input 4: operation code; encodings from package.
REQ-007 Ports EXwn input REGW; EXqa, EXqb, EXimmeOrSa input XLEN: destination register, register operands, immediate/shift amount.
REQ-008 Port EXflush input 1: kill the instruction in EX, including an in-flight multiply.
REQ-009 Port EXstall output 1: upstream holds EX inputs and stops the PC while high.
REQ-010 Ports MEMvalid/MEMwreg/MEMm2reg/MEMwmem output 1; MEMwn output REGW; MEMaluResult, MEMdi output XLEN: registered EX/MEM stage contents.

Function
REQ-011 alua SHALL be EXimmeOrSa when EXshift=1, else EXqa; alub SHALL be EXimmeOrSa when EXaluimm=1, else EXqb.
REQ-012 Single-cycle ops (ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA) SHALL be computed combinationally modulo 2^XLEN; shifts use alua[log2(XLEN)-1:0] as amount, alub as value; LUI = alub shifted left XLEN/2.
REQ-013 A valid single-cycle op with EXflush=0 SHALL load the MEM register at the next edge: MEMvalid=1, controls copied, MEMaluResult=result, MEMdi=EXqb; EXstall=0.
REQ-014 MUL SHALL be an iterative shift-add unit returning the low XLEN bits of the unsigned product; FSM states IDLE, BUSY, DONE.
REQ-015 IDLE + EXvalid + MUL + no flush: EXstall=1 combinationally; latch operands, EXwn and controls; counter:=0; go to BUSY; MEM register loads a bubble.
REQ-016 BUSY: one partial-product step per cycle; EXstall=1; bubbles into MEM; after counter reaches XLEN-1, go to DONE.
REQ-017 DONE: EXstall=0; MEM register loads the latched controls, product and latched EXqb with MEMvalid=1; go to IDLE.
REQ-018 Issue-to-MEMvalid latency for MUL SHALL be XLEN+2 edges; EXstall high for exactly XLEN+1 cycles.
REQ-019 Bubble SHALL mean MEMvalid=MEMwreg=MEMwmem=MEMm2reg=0; data fields don't-care but deterministic (held).
REQ-020 EXflush=1 in any state: FSM to IDLE, EXstall=0 that cycle, bubble loaded; flush wins over simultaneous issue or DONE.
REQ-021 EXvalid=0 in IDLE SHALL load a bubble; undefined EXaluc codes SHALL give result 0 with controls passed.

Reset
REQ-022 clrn low SHALL immediately force FSM=IDLE, counter=0, all MEM outputs 0, EXstall=0, regardless of clk; mid-multiply the operation is discarded.
REQ-023 First edge after clrn rises SHALL behave as IDLE.

Configuration
REQ-024 Macro PIPE_EX_MUL_EN defined: MUL and FSM compiled in as above.
REQ-025 PIPE_EX_MUL_EN undefined: no FSM/multiplier; MUL treated as undefined code (result 0, single cycle); EXstall tied 0.

Structure
REQ-026 Package pipe_ex_pkg SHALL hold the EXaluc encodings and FSM state typedef.
REQ-027 Multiplier (datapath, counter, FSM) SHALL be sub-module pipe_ex_mul; ALU and EX/MEM register stay in pipe_ex_mc.

Verification
REQ-028 ADD, EXqa=5, EXqb=7, EXwn=3, EXwreg=1 -> next edge MEMaluResult=12, MEMwn=3, MEMvalid=1, EXstall=0.
REQ-029 SRA, EXshift=1, EXimmeOrSa=4, EXqb=0x80000000 -> MEMaluResult=0xF8000000.
REQ-030 MUL 0x10000 x 0x10001 (XLEN=32) -> EXstall high 33 cycles, 33 bubbles, then MEMaluResult=0x00010000, MEMvalid=1.
REQ-031 MUL issued, EXflush at BUSY cycle 10 -> EXstall low that cycle, bubble, FSM IDLE; following ADD completes in 1 cycle.
REQ-032 clrn pulsed low mid-multiply between edges -> MEM outputs 0 immediately; after release, single-cycle op completes normally.
REQ-033 Build without PIPE_EX_MUL_EN; issue MUL -> MEMaluResult=0 after one edge, EXstall never high.
